// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel prescaler, h/v position counters and registered sync/blank decode.
// Latency: all decoded outputs change on the same clk_d edge as pixel_x/pixel_y; free-running, no backpressure.
module vga_sync_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_DIV  = 1,
  parameter int SYNC_POL = 0
) (
  input  logic       clk_d,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [1:0] DIV_MAX  = 2'(PIX_DIV - 1);
  localparam logic       SYNC_ACT = (SYNC_POL != 0);

  logic [1:0] div_cnt;
  logic       run;
  logic       adv;
  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;

  assign pix_tick = (div_cnt == DIV_MAX);
  // The first edge after reset only loads the (0,0) decode; counting begins after it.
  assign adv      = pix_tick & run;
  assign h_wrap   = (pixel_x == H_LAST);
  assign v_wrap   = (pixel_y == V_LAST);

  always_comb begin
    h_nxt = pixel_x;
    v_nxt = pixel_y;
    if (adv) begin
      if (h_wrap) begin
        h_nxt = 10'd0;
        v_nxt = v_wrap ? 10'd0 : pixel_y + 10'd1;
      end else begin
        h_nxt = pixel_x + 10'd1;
      end
    end
  end

  // Decode from the next position so sync/blank carry zero skew against pixel_x/pixel_y.
  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= 2'd0;
      run         <= 1'b0;
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= pix_tick ? 2'd0 : div_cnt + 2'd1;
      run         <= 1'b1;
      pixel_x     <= h_nxt;
      pixel_y     <= v_nxt;
      video_on    <= (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);
      hsync       <= ((h_nxt >= HS_BEG) && (h_nxt <= HS_END)) ? SYNC_ACT : ~SYNC_ACT;
      vsync       <= ((v_nxt >= VS_BEG) && (v_nxt <= VS_END)) ? SYNC_ACT : ~SYNC_ACT;
      line_start  <= adv & h_wrap;
      frame_start <= adv & h_wrap & v_wrap;
    end
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator that produces the raster position and sync signals consumed by the screen renderers (start screen, game field, score overlay).
- Drives pixel_x, pixel_y and video_on into the renderers, and hsync/vsync to the VGA connector.
- Default timing is 640x480 @ 60 Hz.
- An internal prescaler derives the pixel rate from clk_d, so the same block serves 25 MHz (PIX_DIV=1) and 50 MHz (PIX_DIV=2) clocking.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
PIX_DIV, 1, clk_d cycles per pixel (1..4)
SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)

Ports:
clk_d  input  1  system/pixel clock
rst_n  input  1  asynchronous active-low reset
pix_tick  output  1  high for one clk_d cycle per pixel period
pixel_x  output  10  current horizontal count, 0..H_TOT-1
pixel_y  output  10  current vertical count, 0..V_TOT-1
video_on  output  1  high when pixel_x<H_VIS and pixel_y<V_VIS
hsync  output  1  horizontal sync, polarity per SYNC_POL
vsync  output  1  vertical sync, polarity per SYNC_POL
line_start  output  1  one-cycle pulse when pixel_x becomes 0
frame_start  output  1  one-cycle pulse when (pixel_x,pixel_y) becomes (0,0)

Behaviour:
- H_TOT = H_VIS+H_FP+H_SYNC+H_BP (default 800). V_TOT is the sum of the V_* parameters (default 525).
- Prescaler:
  - div_cnt counts 0..PIX_DIV-1 and wraps.
  - pix_tick = (div_cnt == PIX_DIV-1).
  - With PIX_DIV=1, pix_tick is constantly 1 after reset.
- Counters advance only on clk_d edges where pix_tick=1:
  - h_cnt increments.
  - At H_TOT-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOT-1 to 0 on the same edge where h_cnt wraps from H_TOT-1.
  - Counters are unsigned 10 bit and never exceed H_TOT-1 / V_TOT-1.
- pixel_x = h_cnt and pixel_y = v_cnt, driven directly from the counter registers.
- Output alignment:
  - video_on, hsync, vsync, line_start and frame_start are registered.
  - They are computed from the next counter values, so they update on the same edge as pixel_x/pixel_y. Zero skew relative to position.
- Sync windows:
  - hsync is active for H_VIS+H_FP <= pixel_x <= H_VIS+H_FP+H_SYNC-1 (default 656..751).
  - vsync is active for V_VIS+V_FP <= pixel_y <= V_VIS+V_FP+V_SYNC-1 (default 490..491), over whole lines.
- Pulse outputs:
  - line_start asserts for exactly one clk_d cycle (not one pixel period) on the edge where h_cnt loads 0.
  - frame_start is the same, but only when v_cnt also loads 0.
- Reset (rst_n=0, asynchronous):
  - div_cnt=0, pixel_x=0, pixel_y=0, video_on=0.
  - hsync and vsync at their inactive level (1 for SYNC_POL=0).
  - line_start=0, frame_start=0.
- After reset release:
  - On the first clk_d edge, registered outputs load the decode of position (0,0): video_on=1, syncs inactive.
  - frame_start and line_start do not pulse for this initial (0,0).
  - Counting starts with the first pix_tick.
- Reset mid-frame: all state returns to reset values immediately without waiting for a clock. There are no partial sync pulses beyond the reset assertion.
- No other inputs; the block free-runs.

Test Plan:
- Reset and release, PIX_DIV=1, default timing:
  - During reset: pixel_x=0, pixel_y=0, video_on=0, hsync=1, vsync=1.
  - One edge after release: video_on=1.
  - pixel_x reaches 1 on the next edge.
- Horizontal line, 800 ticks observed on a visible line:
  - video_on=1 for pixel_x 0..639 and 0 for 640..799.
  - hsync=0 exactly for pixel_x 656..751 (96 cycles).
- Line wrap (pixel_x=799, pixel_y=10): next edge gives pixel_x=0, pixel_y=11, and line_start=1 for one cycle.
- Full frame:
  - vsync=0 only while pixel_y is 490..491 (1600 pixel ticks).
  - (799,524) wraps to (0,0) with frame_start=1.
  - Frame period is 420000 ticks, measured start to start.
- PIX_DIV=2:
  - pix_tick alternates 0/1.
  - pixel_x advances every 2 clk_d cycles.
  - line_start lasts 1 clk_d cycle.
  - Frame period is 840000 clk_d cycles.
- Reset asserted mid-frame at (700,300) during the hsync window:
  - Outputs go to reset values asynchronously (hsync=1 before the next edge).
  - After release, counting restarts from (0,0).
